// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC pipeline.
// Used by the fetch, decode and hazard units.
package risc_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'hFFFF;

  typedef enum logic {
    IF_RUN,
    IF_HALT
  } if_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Flush writes the NOP word and wins over load.
module if_id_reg
  import risc_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP = NOP_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP;
      pc_q    <= pc_i;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, RUN/HALT FSM and IF/ID register.
// Define IF_PERF_COUNT_EN to add fetch/bubble counters.
module instruction_fetch_unit
  import risc_pkg::*;
#(
  parameter int unsigned        IMEM_DEPTH = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_WORD   = risc_pkg::NOP_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               halted
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_bubbles
`endif
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              load, flush;
  logic              in_range;

  // 17-bit compare so IMEM_DEPTH = 65536 covers every address
  assign in_range = ({1'b0, pc_q} < 17'(IMEM_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IF_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IF_RUN: begin
        if (redirect_valid) begin
          pc_d  = redirect_pc;
          flush = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (in_range) begin
          pc_d = pc_q + 16'd1;
          load = 1'b1;
        end else begin
          flush   = 1'b1;
          state_d = IF_HALT;
        end
      end
      IF_HALT: begin
        flush = 1'b1;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = IF_RUN;
        end
      end
      default: state_d = IF_RUN;
    endcase
  end

  if_id_reg #(
    .NOP(NOP_WORD)
  ) u_if_id (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .flush_i(flush),
    .instr_i(imem_data),
    .pc_i   (pc_q),
    .instr_o(if_id_instr),
    .pc_o   (if_id_pc),
    .valid_o(if_id_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = (state_q == IF_HALT);

`ifdef IF_PERF_COUNT_EN
  logic [15:0] fetched_q, fetched_d;
  logic [15:0] bubbles_q, bubbles_d;

  always_comb begin
    fetched_d = fetched_q;
    bubbles_d = bubbles_q;
    if (load && fetched_q != 16'hFFFF)
      fetched_d = fetched_q + 16'd1;
    if (flush && bubbles_q != 16'hFFFF)
      bubbles_d = bubbles_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`endif

endmodule
